inv_key_expansion: RTL and testbench
====================================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameter KEY_LENGTH, default 128: AES-128 key and round-key width.
REQ-002 Parameter WORD_LENGTH, default 32: key-schedule word width.
REQ-003 Parameter Nr, default 10: number of rounds; the round index counts Nr down to 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  last_key is valid.
REQ-007 i_ready  output  1  block can accept last_key.
REQ-008 last_key  input  KEY_LENGTH  round-Nr key; word 0 is bits [127:96].
REQ-009 o_valid  output  1  round_key and round_idx are valid.
REQ-010 o_ready  input  1  downstream accepts the current round key.
REQ-011 round_key  output  KEY_LENGTH  current round key.
REQ-012 round_idx  output  4  index of round_key, Nr down to 0.
REQ-013 o_last  output  1  high together with o_valid when round_idx == 0.

Function
REQ-014 FSM states SHALL be IDLE and EMIT.
REQ-015 In IDLE: i_ready=1, o_valid=0; on i_valid, load last_key, set idx=Nr, go to EMIT.
REQ-016 In EMIT: o_valid=1, round_key=key register, round_idx=idx.
REQ-017 First round key SHALL appear on the cycle after input acceptance (1-cycle latency).
REQ-018 Handshake in EMIT with idx>0: key register <= inverse step of itself, idx <= idx-1.
REQ-019 Inverse step, with words w0..w3 at round i:
  - p3=w3^w2
  - p2=w2^w1
  - p1=w1^w0
  - p0=w0^SubWord(RotWord(p3))^{Rcon[i],24'h0}
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-021 RotWord: bytes {a,b,c,d} -> {b,c,d,a}. SubWord: AES forward S-box applied to each byte.
REQ-022 While o_valid=1 and o_ready=0, round_key, round_idx and o_last SHALL hold stable.
REQ-023 Each input key SHALL produce exactly Nr+1 output beats.
REQ-024 In EMIT: i_ready=0 except in the final-beat cycle (idx==0 and o_ready=1), where i_ready=1.
REQ-025 Final handshake with i_valid=1: load the new key, idx=Nr, stay in EMIT; no bubble.
REQ-026 Final handshake with i_valid=0: go to IDLE.
REQ-027 i_valid while i_ready=0 SHALL be ignored and SHALL NOT corrupt state.
REQ-028 One round key per cycle SHALL be emitted while o_ready is held high.

Reset
REQ-029 On reset low, asynchronously: state=IDLE, idx=0, key register=0, o_valid=0, o_last=0, round_key=0, round_idx=0.
REQ-030 i_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-031 Reset asserted mid-EMIT SHALL abort the sequence; after release no further beats of that key are emitted.

Structure
REQ-032 A shared package SHALL hold the Rcon table, Nr, KEY_LENGTH/WORD_LENGTH constants and the FSM state encoding.
REQ-033 One sub-module aes_sbox (8-bit combinational forward S-box) SHALL be instantiated 4 times for SubWord.
REQ-034 The block SHALL be fully iterative: one inverse-step datapath, no stored schedule.

Verification
REQ-035 FIPS-197 key, o_ready=1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> beat 0: idx 10, that key; beat 1: idx 9, ac7766f319fadc2128d12941575c006e; beat 10: idx 0, 2b7e151628aed2a6abf7158809cf4f3c with o_last=1.
REQ-036 Backpressure: same key, o_ready toggling with a 3-cycle-low pattern -> identical 11-beat sequence; outputs stable during stalls.
REQ-037 Back-to-back: second key presented with i_valid during the final beat -> accepted in the same cycle; its idx-10 beat follows on the next cycle.
REQ-038 Reset mid-sequence: reset low at idx 5 -> o_valid=0 immediately; after release, i_ready=1 and a new key yields a full 11 beats.
REQ-039 Ignored input: i_valid pulsed with a different key during EMIT -> output sequence unchanged.
REQ-040 Random keys: compare against a forward key-expansion model; all 11 round keys match in reverse order.

Source files
------------

// File: rtl/inv_key_expansion_pkg.sv
// Shared constants for the iterative AES-128 inverse key schedule: widths, round count,
// FSM encoding and the round-constant table.
package inv_key_expansion_pkg;

  localparam int unsigned KeyLen    = 128;
  localparam int unsigned WordLen   = 32;
  localparam int unsigned NumRounds = 10;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    rc = 8'h00;
    unique case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_expansion_aes_sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SboxTable = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SboxTable[in_byte];

endmodule

// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: takes the last round key and emits round keys
// Nr down to 0, one per accepted beat, through a single inverse-step datapath.
module inv_key_expansion
  import inv_key_expansion_pkg::*;
#(
  parameter int KEY_LENGTH  = KeyLen,
  parameter int WORD_LENGTH = WordLen,
  parameter int Nr          = NumRounds
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [KEY_LENGTH-1:0] last_key,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [KEY_LENGTH-1:0] round_key,
  output logic [3:0]            round_idx,
  output logic                  o_last
);

  localparam int W = WORD_LENGTH;

  logic [0:0]            state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [KEY_LENGTH-1:0] key_q, key_d;

  logic [W-1:0] w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
  logic         emit, accept;

  assign w0 = key_q[KEY_LENGTH-1 -: W];
  assign w1 = key_q[KEY_LENGTH-1-W -: W];
  assign w2 = key_q[KEY_LENGTH-1-2*W -: W];
  assign w3 = key_q[KEY_LENGTH-1-3*W -: W];

  // p3 is the previous round's last word, which feeds the schedule's g() function.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[W-9:0], p3[W-1 -: 8]};

  for (genvar b = 0; b < W / 8; b++) begin : gen_subword
    aes_sbox u_sbox (
      .in_byte  (rot[8*b +: 8]),
      .out_byte (sub[8*b +: 8])
    );
  end

  assign p0 = w0 ^ sub ^ {rcon(idx_q), {(W - 8){1'b0}}};

  assign emit      = (state_q == StEmit);
  assign o_valid   = emit;
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign o_last    = emit && (idx_q == 4'd0);

  // The final beat frees the block, so a new key can be taken without a bubble.
  assign i_ready = reset && (!emit || ((idx_q == 4'd0) && o_ready));
  assign accept  = i_valid && i_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    if (accept) begin
      state_d = StEmit;
      idx_d   = 4'(Nr);
      key_d   = last_key;
    end else if (emit && o_ready) begin
      if (idx_q == 4'd0) begin
        state_d = StIdle;
      end else begin
        idx_d = idx_q - 4'd1;
        key_d = {p0, p1, p2, p3};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed and random checks of the inverse key schedule against a forward-expansion model.
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [127:0] last_key = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         o_last;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_key [11];
  logic         got_last [11];

  typedef struct {
    int           idx;
    logic [127:0] key;
    logic         last;
  } vec_t;
  vec_t tab [3];

  localparam logic [127:0] FipsK0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsLast = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  inv_key_expansion dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .last_key  (last_key),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .o_last    (o_last)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box derived from the GF(2^8) inverse and affine map, independent of any table.
  function automatic logic [7:0] sbox_of(input int a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] k0);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    w0 = k0[127:96];
    w1 = k0[95:64];
    w2 = k0[63:32];
    w3 = k0[31:0];
    rc = 8'h01;
    exp_rk[0] = k0;
    for (int r = 1; r <= 10; r++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("%s_rk%0d", tag, r), got_key[r], exp_rk[r]);
    end
  endtask

  task automatic compare_tab(input string tag);
    for (int v = 0; v < 3; v++) begin
      check($sformatf("%s_tab_key%0d", tag, tab[v].idx), got_key[tab[v].idx], tab[v].key);
      check($sformatf("%s_tab_last%0d", tag, tab[v].idx), 128'(got_last[tab[v].idx]),
            128'(tab[v].last));
    end
  endtask

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic run_seq(input logic [127:0] k, input bit bp, input bit poke, input bit preloaded,
                         input bit chain, input logic [127:0] next_k);
    int         beats = 0;
    int         cyc = 0;
    bit         prev_stall = 0;
    logic [127:0] pk;
    logic [3:0] pi;
    logic       pl;
    pk = '0;
    pi = '0;
    pl = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      got_key[r]  = 'x;
      got_last[r] = 1'bx;
    end
    if (!preloaded) begin
      i_valid  = 1'b1;
      last_key = k;
      o_ready  = 1'b0;
      #1;
      check("accept_ready", 128'(i_ready), 128'd1);
      @(posedge clk);
      #1;
      i_valid  = 1'b0;
      last_key = '0;
    end
    while (beats < 11 && cyc < 100) begin
      o_ready = bp ? (cyc % 4 == 3) : 1'b1;
      i_valid = 1'b0;
      if (poke && cyc == 2) begin
        i_valid  = 1'b1;
        last_key = ~k;
      end
      if (chain && beats == 10 && o_ready) begin
        i_valid  = 1'b1;
        last_key = next_k;
      end
      #1;
      check("o_valid", 128'(o_valid), 128'd1);
      if (prev_stall) begin
        check("hold_key", round_key, pk);
        check("hold_idx", 128'(round_idx), 128'(pi));
        check("hold_last", 128'(o_last), 128'(pl));
      end
      if (poke && cyc == 2) check("busy_ready", 128'(i_ready), 128'd0);
      if (o_ready) begin
        check("idx", 128'(round_idx), 128'(10 - beats));
        check("o_last", 128'(o_last), 128'(beats == 10));
        if (chain && beats == 10) check("chain_ready", 128'(i_ready), 128'd1);
        if (round_idx <= 4'd10) begin
          got_key[round_idx]  = round_key;
          got_last[round_idx] = o_last;
        end
        beats++;
        prev_stall = 0;
      end else begin
        pk = round_key;
        pi = round_idx;
        pl = o_last;
        prev_stall = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_valid = 1'b0;
    o_ready = 1'b0;
    check("beat_count", 128'(beats), 128'd11);
    if (!chain) begin
      check("idle_valid", 128'(o_valid), 128'd0);
      check("idle_ready", 128'(i_ready), 128'd1);
    end
  endtask

  initial begin
    logic [127:0] ka, kb, la, lb, kr;

    for (int a = 0; a < 256; a++) sb[a] = sbox_of(a);
    tab[0] = '{10, FipsLast, 1'b0};
    tab[1] = '{9, 128'hac7766f319fadc2128d12941575c006e, 1'b0};
    tab[2] = '{0, FipsK0, 1'b1};

    // Reset values while held
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", 128'(o_valid), 128'd0);
    check("rst_i_ready", 128'(i_ready), 128'd0);
    check("rst_round_key", round_key, 128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd0);
    check("rst_o_last", 128'(o_last), 128'd0);
    reset = 1'b1;
    #1;
    check("post_rst_ready", 128'(i_ready), 128'd1);
    @(posedge clk);
    #1;

    // FIPS-197 key, full throughput
    expand(FipsK0);
    run_seq(FipsLast, 0, 0, 0, 0, '0);
    compare_tab("fips");
    compare_model("fips");

    // Backpressure: 3 cycles low, 1 high
    run_seq(FipsLast, 1, 0, 0, 0, '0);
    compare_tab("bp");
    compare_model("bp");

    // Ignored input while busy
    run_seq(FipsLast, 0, 1, 0, 0, '0);
    compare_model("ignore");

    // Back-to-back keys, no bubble
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    expand(kb);
    lb = exp_rk[10];
    expand(ka);
    la = exp_rk[10];
    run_seq(la, 0, 0, 0, 1, lb);
    compare_model("b2b_a");
    expand(kb);
    run_seq(lb, 0, 0, 1, 0, '0);
    compare_model("b2b_b");

    // Reset in the middle of a sequence
    i_valid  = 1'b1;
    last_key = FipsLast;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 20 && !(o_valid && round_idx == 4'd5); c++) begin
      @(posedge clk);
      #1;
    end
    check("reach_idx5", 128'(round_idx), 128'd5);
    reset = 1'b0;
    #1;
    check("abort_o_valid", 128'(o_valid), 128'd0);
    check("abort_i_ready", 128'(i_ready), 128'd0);
    check("abort_round_key", round_key, 128'd0);
    check("abort_round_idx", 128'(round_idx), 128'd0);
    check("abort_o_last", 128'(o_last), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rerelease_ready", 128'(i_ready), 128'd1);
    @(posedge clk);
    #1;
    check("no_stale_beat", 128'(o_valid), 128'd0);
    kr = {$urandom, $urandom, $urandom, $urandom};
    expand(kr);
    run_seq(exp_rk[10], 0, 0, 0, 0, '0);
    compare_model("after_rst");

    // Random keys, one with backpressure
    for (int n = 0; n < 3; n++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      expand(kr);
      run_seq(exp_rk[10], (n == 1), 0, 0, 0, '0);
      compare_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
